// File: rtl/lstm_ctrl_pkg.sv
// Shared types and register-map helpers for the LSTM sequencer.
package lstm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int unsigned KIND_WX = 0;
  localparam int unsigned KIND_WH = 1;
  localparam int unsigned KIND_BX = 2;
  localparam int unsigned KIND_BH = 3;

  localparam int unsigned CTRL_CLEAR_BIT = 31;

  function automatic int unsigned state_base(input int unsigned layers);
    return 16 * layers;
  endfunction

  function automatic int unsigned ctrl_index(input int unsigned layers);
    return 20 * layers;
  endfunction

endpackage

// File: rtl/lstm_sequencer_if.sv
// Register-update write port from the AXI4-Lite slave.
interface lstm_sequencer_if;
  logic [31:0] update_addr;
  logic [31:0] update_data;
  logic        update_valid;

  modport master (output update_addr, update_data, update_valid);
  modport slave  (input  update_addr, update_data, update_valid);
endinterface

// File: rtl/lstm_sequencer_fifo.sv
// Synchronous FIFO with occupancy count; caller never pushes when full without a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/lstm_sequencer.sv
// Register-write decoder, x-sample issue FSM and result capture for the LSTM datapath.
module lstm_sequencer
  import lstm_ctrl_pkg::*;
#(
  parameter int unsigned LAYERS     = 4,
  parameter int unsigned WEIGHTS    = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  lstm_sequencer_if.slave                   upd,
  output logic [LAYERS*WEIGHTS*WIDTH-1:0]   weight_x,
  output logic [LAYERS*WEIGHTS*WIDTH-1:0]   weight_h,
  output logic [LAYERS*WEIGHTS*WIDTH-1:0]   bias_x,
  output logic [LAYERS*WEIGHTS*WIDTH-1:0]   bias_h,
  output logic [LAYERS*WEIGHTS-1:0]         weight_x_valid,
  output logic [LAYERS*WEIGHTS-1:0]         weight_h_valid,
  output logic [LAYERS*WEIGHTS-1:0]         bias_x_valid,
  output logic [LAYERS*WEIGHTS-1:0]         bias_h_valid,
  output logic [LAYERS*WIDTH-1:0]           C_in,
  output logic [LAYERS*WIDTH-1:0]           h_in,
  output logic [LAYERS-1:0]                 C_in_valid,
  output logic [LAYERS-1:0]                 h_in_valid,
  input  logic                              ready,
  output logic [WIDTH-1:0]                  x_in,
  output logic                              x_in_valid,
  input  logic [WIDTH-1:0]                  y_out,
  input  logic [WIDTH-1:0]                  C_out,
  input  logic                              valid,
  output logic [WIDTH-1:0]                  y_result,
  output logic [WIDTH-1:0]                  C_result,
  output logic                              result_valid,
  output logic [15:0]                       sample_count,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              busy,
  output logic                              overflow,
  output logic                              param_err
);
  localparam int unsigned SLOTS = LAYERS * WEIGHTS;
  localparam int unsigned SW    = (SLOTS > 1)  ? $clog2(SLOTS)  : 1;
  localparam int unsigned LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam logic [29:0] SBASE = 30'(state_base(LAYERS));
  localparam logic [29:0] CIDX  = 30'(ctrl_index(LAYERS));
  localparam logic [29:0] KSPAN = 30'(4 * LAYERS);
  localparam logic [29:0] LSPAN = 30'(LAYERS);

  state_t           state;
  logic [29:0]      idx;
  logic [1:0]       kind;
  logic [SW-1:0]    slot;
  logic [1:0]       skind;
  logic [LW-1:0]    layer;
  logic             wr_ok, param_wr, state_wr, ctrl_wr, clear_req, push_req;
  logic             push, pop, full, empty, busy_now;
  logic [WIDTH-1:0] head, wdata;
  logic             unused_data;

  always_comb begin
    idx       = upd.update_addr[31:2];
    wdata     = upd.update_data[WIDTH-1:0];
    kind      = 2'(idx / KSPAN);
    slot      = SW'(idx % KSPAN);
    skind     = 2'((idx - SBASE) / LSPAN);
    layer     = LW'(idx % LSPAN);
    wr_ok     = upd.update_valid && (upd.update_addr[1:0] == 2'b00);
    param_wr  = wr_ok && (idx < SBASE);
    // Only the C and h sub-regions of the state block are live; k=2,3 are reserved.
    state_wr  = wr_ok && (idx >= SBASE) && (idx < CIDX) && (skind < 2'd2);
    ctrl_wr   = wr_ok && (idx == CIDX);
    clear_req = ctrl_wr && upd.update_data[CTRL_CLEAR_BIT];
    push_req  = ctrl_wr && !upd.update_data[CTRL_CLEAR_BIT];
  end

  assign pop      = (state == IDLE) && !empty && ready;
  assign push     = push_req && (!full || pop);
  assign busy_now = (state != IDLE) || !empty;
  assign busy     = busy_now;

  assign unused_data = ^upd.update_data[30:WIDTH];

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .din   (wdata),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      weight_x       <= '0;
      weight_h       <= '0;
      bias_x         <= '0;
      bias_h         <= '0;
      weight_x_valid <= '0;
      weight_h_valid <= '0;
      bias_x_valid   <= '0;
      bias_h_valid   <= '0;
      C_in           <= '0;
      h_in           <= '0;
      C_in_valid     <= '0;
      h_in_valid     <= '0;
      x_in           <= '0;
      x_in_valid     <= 1'b0;
      y_result       <= '0;
      C_result       <= '0;
      result_valid   <= 1'b0;
      sample_count   <= '0;
      overflow       <= 1'b0;
      param_err      <= 1'b0;
    end else begin
      weight_x_valid <= '0;
      weight_h_valid <= '0;
      bias_x_valid   <= '0;
      bias_h_valid   <= '0;
      C_in_valid     <= '0;
      h_in_valid     <= '0;
      x_in_valid     <= 1'b0;
      result_valid   <= 1'b0;

      if (param_wr || state_wr) begin
        if (busy_now) begin
          param_err <= 1'b1;
        end else if (param_wr) begin
          case (kind)
            2'(KIND_WX): begin weight_x <= {SLOTS{wdata}}; weight_x_valid[slot] <= 1'b1; end
            2'(KIND_WH): begin weight_h <= {SLOTS{wdata}}; weight_h_valid[slot] <= 1'b1; end
            2'(KIND_BX): begin bias_x   <= {SLOTS{wdata}}; bias_x_valid[slot]   <= 1'b1; end
            default:     begin bias_h   <= {SLOTS{wdata}}; bias_h_valid[slot]   <= 1'b1; end
          endcase
        end else if (skind == 2'd0) begin
          C_in[layer*WIDTH +: WIDTH] <= wdata;
          C_in_valid[layer]          <= 1'b1;
        end else begin
          h_in[layer*WIDTH +: WIDTH] <= wdata;
          h_in_valid[layer]          <= 1'b1;
        end
      end

      if (clear_req) begin
        overflow  <= 1'b0;
        param_err <= 1'b0;
      end
      if (push_req && full && !pop) overflow <= 1'b1;

      // The pop happens on the IDLE->ISSUE edge so x_in_valid is visible throughout ISSUE.
      unique case (state)
        IDLE: begin
          if (pop) begin
            x_in       <= head;
            x_in_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (valid) begin
            y_result     <= y_out;
            C_result     <= C_out;
            result_valid <= 1'b1;
            sample_count <= sample_count + 16'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_sequencer.sv
// Scoreboard bench for lstm_sequencer: register decode, sample issue/result flow, flags and reset.
module tb_lstm_sequencer;
  localparam int unsigned L  = 4;
  localparam int unsigned WG = 4;
  localparam int unsigned WD = 16;
  localparam int unsigned FD = 8;
  localparam int unsigned NS = L * WG;
  localparam logic [31:0] CTRL_ADDR = 32'd320;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lstm_sequencer_if upd();

  logic [NS*WD-1:0] weight_x, weight_h, bias_x, bias_h;
  logic [NS-1:0]    weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid;
  logic [L*WD-1:0]  C_in, h_in;
  logic [L-1:0]     C_in_valid, h_in_valid;
  logic             ready, x_in_valid, valid, result_valid, busy, overflow, param_err;
  logic [WD-1:0]    x_in, y_out, C_out, y_result, C_result;
  logic [15:0]      sample_count;
  logic [3:0]       fifo_level;

  lstm_sequencer #(.LAYERS(L), .WEIGHTS(WG), .WIDTH(WD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .upd(upd),
    .weight_x(weight_x), .weight_h(weight_h), .bias_x(bias_x), .bias_h(bias_h),
    .weight_x_valid(weight_x_valid), .weight_h_valid(weight_h_valid),
    .bias_x_valid(bias_x_valid), .bias_h_valid(bias_h_valid),
    .C_in(C_in), .h_in(h_in), .C_in_valid(C_in_valid), .h_in_valid(h_in_valid),
    .ready(ready), .x_in(x_in), .x_in_valid(x_in_valid),
    .y_out(y_out), .C_out(C_out), .valid(valid),
    .y_result(y_result), .C_result(C_result), .result_valid(result_valid),
    .sample_count(sample_count), .fifo_level(fifo_level),
    .busy(busy), .overflow(overflow), .param_err(param_err)
  );

  typedef struct { int kind; int slot; logic [15:0] data; } strobe_t;
  typedef struct { logic [15:0] y; logic [15:0] c; logic [15:0] cnt; int due; } res_t;

  strobe_t     sq[$];
  res_t        rq[$];
  logic [15:0] xq[$];
  int unsigned checks = 0, errors = 0;
  int          cyc = 0, outstanding = 0, epoch = 0, lat = 3;
  logic [15:0] model_cnt = '0;
  bit          exp_ovf = 0, exp_perr = 0, rand_ready = 0;
  logic        ready_fixed = 1'b0, rr = 1'b0;

  assign ready = rand_ready ? rr : ready_fixed;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin #1; rr = 1'($urandom_range(0, 1)); end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] onehot(int kind, int want, int slot);
    return (kind == want) ? (64'd1 << slot) : 64'd0;
  endfunction

  // Strobe monitor: every observed strobe cycle consumes one expected write.
  strobe_t s_cur;
  logic [NS*WD-1:0] bus_sel;
  always @(negedge clk) begin
    if (rst && ($countones({weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid,
                            C_in_valid, h_in_valid}) != 0)) begin
      if (sq.size() == 0) begin
        chk("spurious_strobe", 64'($countones({weight_x_valid, weight_h_valid, bias_x_valid,
                                               bias_h_valid, C_in_valid, h_in_valid})), 64'd0);
      end else begin
        s_cur = sq.pop_front();
        chk("wx_valid", 64'(weight_x_valid), onehot(s_cur.kind, 0, s_cur.slot));
        chk("wh_valid", 64'(weight_h_valid), onehot(s_cur.kind, 1, s_cur.slot));
        chk("bx_valid", 64'(bias_x_valid),   onehot(s_cur.kind, 2, s_cur.slot));
        chk("bh_valid", 64'(bias_h_valid),   onehot(s_cur.kind, 3, s_cur.slot));
        chk("c_valid",  64'(C_in_valid),     onehot(s_cur.kind, 4, s_cur.slot));
        chk("h_valid",  64'(h_in_valid),     onehot(s_cur.kind, 5, s_cur.slot));
        if (s_cur.kind < 4) begin
          case (s_cur.kind)
            0: bus_sel = weight_x;
            1: bus_sel = weight_h;
            2: bus_sel = bias_x;
            default: bus_sel = bias_h;
          endcase
          for (int j = 0; j < NS; j++) chk("param_bus", 64'(bus_sel[j*WD +: WD]), 64'(s_cur.data));
        end else if (s_cur.kind == 4) begin
          chk("c_in_bus", 64'(C_in[s_cur.slot*WD +: WD]), 64'(s_cur.data));
        end else begin
          chk("h_in_bus", 64'(h_in[s_cur.slot*WD +: WD]), 64'(s_cur.data));
        end
      end
    end
  end

  // Result monitor.
  res_t r_cur;
  always @(negedge clk) begin
    if (rst && result_valid) begin
      if (rq.size() == 0) begin
        chk("spurious_result", 64'(result_valid), 64'd0);
      end else begin
        r_cur = rq.pop_front();
        chk("y_result", 64'(y_result), 64'(r_cur.y));
        chk("C_result", 64'(C_result), 64'(r_cur.c));
        chk("sample_count", 64'(sample_count), 64'(r_cur.cnt));
        chk("result_time", 64'(cyc), 64'(r_cur.due));
        outstanding--;
      end
    end
  end

  // Datapath model: y = x+2, C = x+4, answered lat cycles after each issue.
  logic [15:0] xe;
  int          ep;
  initial begin
    valid = 1'b0; y_out = '0; C_out = '0;
    forever begin
      @(negedge clk);
      if (rst && x_in_valid) begin
        ep = epoch;
        xe = x_in;
        if (xq.size() == 0) chk("spurious_issue", 64'(x_in_valid), 64'd0);
        else begin xe = xq.pop_front(); chk("x_in", 64'(x_in), 64'(xe)); end
        repeat (lat) @(posedge clk);
        #1;
        valid = 1'b1; y_out = xe + 16'd2; C_out = xe + 16'd4;
        if (ep == epoch) begin
          model_cnt++;
          rq.push_back('{xe + 16'd2, xe + 16'd4, model_cnt, cyc + 1});
        end
        @(posedge clk); #1;
        valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit busy_exp);
    int unsigned i;
    i = a >> 2;
    if (a[1:0] == 2'b00 && i <= 80) begin
      if (i < 72) begin
        if (busy_exp) exp_perr = 1;
        else if (i < 64) sq.push_back('{int'(i / 16), int'(i % 16), d[15:0]});
        else sq.push_back('{4 + int'((i - 64) / 4), int'(i % 4), d[15:0]});
      end else if (i == 80) begin
        if (d[31]) begin exp_ovf = 0; exp_perr = 0; end
        else if (xq.size() < FD) begin xq.push_back(d[15:0]); outstanding++; end
        else exp_ovf = 1;
      end
    end
    upd.update_addr = a; upd.update_data = d; upd.update_valid = 1'b1;
    tick();
    upd.update_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((outstanding != 0 || xq.size() != 0) && n < 3000) begin tick(); n++; end
    if (n >= 3000) chk("drain_timeout", 64'(outstanding), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    upd.update_addr = '0; upd.update_data = '0; upd.update_valid = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_count", 64'(sample_count), 0);
    chk("rst_flags", 64'({overflow, param_err, x_in_valid, result_valid}), 0);
    chk("rst_strobes", 64'({weight_h_valid, C_in_valid, h_in_valid}), 0);
    rst = 1'b1;
    tick();

    wr(32'h44, 32'h0000_1234, 0);
    wr(32'd68 * 4, 32'h0000_ABCD, 0);
    wr(32'd75 * 4, 32'h0000_ABCD, 0);
    repeat (3) tick();
    chk("strobes_seen", 64'(sq.size()), 0);

    // First sample: issue at T+2, datapath answers three cycles later.
    lat = 3; ready_fixed = 1'b1;
    repeat (2) tick();
    wr(CTRL_ADDR, 32'd5, 0);
    @(negedge clk); chk("issue_t1", 64'(x_in_valid), 0);
    @(negedge clk); chk("issue_t2", 64'(x_in_valid), 1);
    wait_idle();
    chk("count_first", 64'(sample_count), 64'(model_cnt));

    // Overflow with the issue path stalled, then clear.
    ready_fixed = 1'b0;
    for (int j = 0; j < 9; j++) wr(CTRL_ADDR, 32'(100 + j), 0);
    tick();
    chk("level_full", 64'(fifo_level), 64'(xq.size()));
    chk("overflow_set", 64'(overflow), 64'(exp_ovf));
    wr(CTRL_ADDR, 32'h8000_0000, 0);
    tick();
    chk("overflow_clr", 64'(overflow), 64'(exp_ovf));
    chk("level_after_clr", 64'(fifo_level), 64'(xq.size()));
    ready_fixed = 1'b1;
    wait_idle();
    chk("count_drain", 64'(sample_count), 64'(model_cnt));

    // Parameter write while waiting on a result, plus ignored addresses.
    lat = 8;
    wr(CTRL_ADDR, 32'd33, 0);
    repeat (2) tick();
    chk("busy_wait", 64'(busy), 1);
    wr(32'h0, 32'h0000_0077, 1);
    wr(32'h2, 32'h0000_0055, 1);
    wr(32'd81 * 4, 32'h0000_0042, 1);
    tick();
    chk("param_err", 64'(param_err), 64'(exp_perr));
    chk("level_ignored", 64'(fifo_level), 0);
    wait_idle();
    wr(CTRL_ADDR, 32'h8000_0000, 0);
    tick();
    chk("param_err_clr", 64'(param_err), 64'(exp_perr));

    // Random parameter/state writes while idle.
    chk("idle_busy", 64'(busy), 0);
    for (int j = 0; j < 30; j++) begin
      int unsigned i;
      logic [31:0] a;
      i = $urandom_range(0, 80);
      if (i == 80) i = 81;
      a = 32'(i) << 2;
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      wr(a, $urandom, 0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    repeat (3) tick();
    chk("rand_strobes_seen", 64'(sq.size()), 0);
    chk("rand_perr", 64'(param_err), 64'(exp_perr));

    // Random sample stream with random ready and datapath latency.
    rand_ready = 1;
    for (int j = 0; j < 40; j++) begin
      int n;
      n = 0;
      while (xq.size() > 6 && n < 500) begin tick(); n++; end
      lat = $urandom_range(1, 4);
      wr(CTRL_ADDR, {16'h0, 16'($urandom)}, 0);
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 0; ready_fixed = 1'b1;
    wait_idle();
    chk("rand_count", 64'(sample_count), 64'(model_cnt));
    chk("rand_overflow", 64'(overflow), 64'(exp_ovf));

    // Reset in WAIT with samples queued; the late datapath answer must be ignored.
    lat = 20;
    for (int j = 0; j < 4; j++) wr(CTRL_ADDR, 32'(330 + j), 0);
    repeat (3) tick();
    ready_fixed = 1'b0;
    chk("pre_rst_busy", 64'(busy), 1);
    rst = 1'b0;
    epoch++;
    xq.delete(); rq.delete();
    outstanding = 0; model_cnt = '0; exp_ovf = 0; exp_perr = 0;
    tick();
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_level", 64'(fifo_level), 0);
    chk("mid_rst_count", 64'(sample_count), 0);
    chk("mid_rst_x", 64'({x_in, x_in_valid}), 0);
    chk("mid_rst_res", 64'({y_result, C_result, result_valid}), 0);
    chk("mid_rst_wbus", 64'(weight_x[63:0] | weight_h[63:0] | bias_x[63:0] | bias_h[63:0]), 0);
    chk("mid_rst_flags", 64'({overflow, param_err}), 0);
    tick();
    rst = 1'b1;
    repeat (30) tick();
    chk("post_rst_count", 64'(sample_count), 0);

    chk("strobe_q_empty", 64'(sq.size()), 0);
    chk("result_q_empty", 64'(rq.size()), 0);
    chk("x_q_empty", 64'(xq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
